// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gb_mem_pkg
// Description : Shared memory-map constants and OAM DMA state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package gb_mem_pkg;

  localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
  localparam logic [15:0] OAM_BASE        = 16'hFE00;
  localparam int          OAM_LEN_DEFAULT = 160;
  localparam logic [15:0] DMA_IDLE_ADDR   = 16'hFFFF;
  localparam logic [7:0]  ECHO_PAGE_LO    = 8'hE0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    PAD   = 3'd4
  } dma_state_t;

  // Pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] dma_src_page(input logic [7:0] page);
    return (page >= ECHO_PAGE_LO) ? (page - 8'h20) : page;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_engine
// Description : Game Boy OAM DMA controller (FF46) mastering the MMU DMA port.
//               Optional macro OAM_DMA_MCYCLE_ACCURATE_EN pads each byte to 4 clk.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_engine
  import gb_mem_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int OAM_LEN = OAM_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] reg_addr_select,
  input  logic [7:0]  reg_write_value,
  input  logic        reg_write_enable,
  output logic [7:0]  reg_read_out,
  output logic [15:0] dma_addr_select,
  output logic [7:0]  dma_write_value,
  output logic        dma_write_enable,
  input  logic [7:0]  dma_read_out,
  output logic        busy,
  output logic        done
);

`ifdef OAM_DMA_MCYCLE_ACCURATE_EN
  localparam int PAD_CYCLES = 2 - RD_LAT;
`else
  localparam int PAD_CYCLES = 0;
`endif

  localparam logic [1:0] RD_LAST  = 2'(RD_LAT);
  localparam logic [1:0] PAD_LAST = (PAD_CYCLES > 0) ? 2'(PAD_CYCLES - 1) : 2'd0;
  localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);

  generate
    if (RD_LAT < 0 || RD_LAT > 2) begin : g_rd_lat_check
      $error("oam_dma_engine: RD_LAT must be within 0..2");
    end
  endgenerate

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  index_q, index_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        wr_hit;
  logic [15:0] src_addr;

  assign wr_hit   = reg_write_enable && (reg_addr_select == DMA_REG_ADDR);
  assign src_addr = {dma_src_page(page_q), index_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      index_q <= 8'h00;
      data_q  <= 8'h00;
      cnt_q   <= 2'd0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: ;
      START: begin
        index_d = 8'h00;
        cnt_d   = 2'd0;
        state_d = READ;
      end
      READ: begin
        if (cnt_q == RD_LAST) begin
          data_d  = dma_read_out;
          cnt_d   = 2'd0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      WRITE: begin
        if (PAD_CYCLES > 0) begin
          // PAD presents the next source address, so advance now; the last
          // byte keeps its index and remembers it must finish after padding.
          state_d = PAD;
          cnt_d   = 2'd0;
          last_d  = (index_q == IDX_LAST);
          if (index_q != IDX_LAST) index_d = index_q + 8'd1;
        end else if (index_q == IDX_LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
      PAD: begin
        if (cnt_q == PAD_LAST) begin
          cnt_d = 2'd0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = READ;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new FF46 write always wins, including over the final byte's done.
    if (wr_hit) begin
      page_d  = reg_write_value;
      index_d = 8'h00;
      cnt_d   = 2'd0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      state_d = START;
    end
  end

  always_comb begin
    dma_addr_select  = DMA_IDLE_ADDR;
    dma_write_value  = 8'h00;
    dma_write_enable = 1'b0;
    case (state_q)
      READ, PAD: dma_addr_select = src_addr;
      WRITE: begin
        dma_addr_select  = OAM_BASE + {8'h00, index_q};
        dma_write_value  = data_q;
        dma_write_enable = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign reg_read_out = (reg_addr_select == DMA_REG_ADDR) ? page_q : 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma_engine
// Description : Directed self-checking bench for oam_dma_engine (RD_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma_engine;

`ifdef OAM_DMA_MCYCLE_ACCURATE_EN
  localparam int BUSY_EXP = 641;
  localparam int GAP_EXP  = 4;
`else
  localparam int BUSY_EXP = 481;
  localparam int GAP_EXP  = 3;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] reg_addr_select;
  logic [7:0]  reg_write_value;
  logic        reg_write_enable;
  logic [7:0]  reg_read_out;
  logic [15:0] dma_addr_select;
  logic [7:0]  dma_write_value;
  logic        dma_write_enable;
  logic [7:0]  dma_read_out;
  logic        busy;
  logic        done;

  oam_dma_engine #(.RD_LAT(1), .OAM_LEN(160)) u_dut (
    .clk              (clk),
    .rst              (rst),
    .reg_addr_select  (reg_addr_select),
    .reg_write_value  (reg_write_value),
    .reg_write_enable (reg_write_enable),
    .reg_read_out     (reg_read_out),
    .dma_addr_select  (dma_addr_select),
    .dma_write_value  (dma_write_value),
    .dma_write_enable (dma_write_enable),
    .dma_read_out     (dma_read_out),
    .busy             (busy),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    return 8'(a[7:0] * 8'd3 + a[15:8] + 8'h11);
  endfunction

  // Source memory with one cycle of read latency.
  always @(posedge clk) dma_read_out <= src_byte(dma_addr_select);

  logic [7:0] oam [0:159];
  int cyc, busy_cnt, done_cnt, done_busy_bad, wr_cnt, oob, gap_bad, prev_wr;
  int rd_seen, rd_bad;
  bit have_prev;
  logic [15:0] rd_lo, rd_hi;

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
      if (dma_write_enable) begin
        if (dma_addr_select >= 16'hFE00 && dma_addr_select <= 16'hFE9F)
          oam[int'(dma_addr_select - 16'hFE00)] = dma_write_value;
        else
          oob++;
        wr_cnt++;
        if (have_prev && (cyc - prev_wr) != GAP_EXP) gap_bad++;
        prev_wr   = cyc;
        have_prev = 1'b1;
      end else if (busy && dma_addr_select != 16'hFFFF) begin
        rd_seen++;
        if (dma_addr_select < rd_lo || dma_addr_select > rd_hi) rd_bad++;
      end
    end
  end

  task automatic clear_stats(input logic [7:0] fill, input logic [15:0] lo, input logic [15:0] hi);
    busy_cnt = 0; done_cnt = 0; done_busy_bad = 0; wr_cnt = 0; oob = 0;
    gap_bad = 0; have_prev = 1'b0; rd_seen = 0; rd_bad = 0;
    rd_lo = lo; rd_hi = hi;
    for (int i = 0; i < 160; i++) oam[i] = fill;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    reg_addr_select  = a;
    reg_write_value  = v;
    reg_write_enable = 1'b1;
    @(negedge clk);
    reg_write_enable = 1'b0;
    reg_addr_select  = 16'h0000;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 2000) check({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (8) @(negedge clk);
    #1;
  endtask

  task automatic wait_writes(input int target);
    int n;
    n = 0;
    while (wr_cnt < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 2000) check("wr_wait_timeout", 32'd0, 32'd1);
  endtask

  function automatic int oam_diff(input logic [15:0] base, input int lo, input int hi);
    int d;
    d = 0;
    for (int i = lo; i <= hi; i++)
      if (oam[i] !== src_byte(base + 16'(i))) d++;
    return d;
  endfunction

  function automatic int oam_fill_diff(input logic [7:0] fill, input int lo, input int hi);
    int d;
    d = 0;
    for (int i = lo; i <= hi; i++)
      if (oam[i] !== fill) d++;
    return d;
  endfunction

  initial begin
    rst = 1'b0;
    reg_addr_select  = 16'h0000;
    reg_write_value  = 8'h00;
    reg_write_enable = 1'b0;
    clear_stats(8'h00, 16'h0000, 16'hFFFF);
    repeat (3) @(negedge clk);
    #1;

    // Reset state
    check("rst_addr", 32'(dma_addr_select), 32'hFFFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_we", 32'(dma_write_enable), 32'd0);
    check("rst_wv", 32'(dma_write_value), 32'd0);
    reg_addr_select = 16'hFF46; #1;
    check("rst_rd_ff46", 32'(reg_read_out), 32'h00);
    reg_addr_select = 16'hFF47; #1;
    check("rd_other", 32'(reg_read_out), 32'hFF);
    @(negedge clk);
    rst = 1'b1;

    // Write to a neighbouring register must not start a transfer
    cpu_write(16'hFF47, 8'hC1);
    repeat (3) @(negedge clk);
    #1;
    check("wrong_addr_busy", 32'(busy), 32'd0);

    // Plain transfer from C100
    clear_stats(8'h00, 16'hC100, 16'hC19F);
    cpu_write(16'hFF46, 8'hC1);
    wait_done("c1");
    check("c1_oam", 32'(oam_diff(16'hC100, 0, 159)), 32'd0);
    check("c1_busy_len", 32'(busy_cnt), 32'(BUSY_EXP));
    check("c1_done_cnt", 32'(done_cnt), 32'd1);
    check("c1_done_busy", 32'(done_busy_bad), 32'd0);
    check("c1_wr_cnt", 32'(wr_cnt), 32'd160);
    check("c1_oob", 32'(oob), 32'd0);
    check("c1_gap", 32'(gap_bad), 32'd0);
    check("c1_rd_range", 32'(rd_bad), 32'd0);
    reg_addr_select = 16'hFF46; #1;
    check("c1_readback", 32'(reg_read_out), 32'hC1);

    // Echo page F0 reads D000..D09F
    clear_stats(8'h00, 16'hD000, 16'hD09F);
    cpu_write(16'hFF46, 8'hF0);
    wait_done("f0");
    check("f0_oam", 32'(oam_diff(16'hD000, 0, 159)), 32'd0);
    check("f0_rd_range", 32'(rd_bad), 32'd0);
    check("f0_rd_seen", 32'(rd_seen >= 160), 32'd1);
    reg_addr_select = 16'hFF46; #1;
    check("f0_readback", 32'(reg_read_out), 32'hF0);

    // Restart with C2 at byte 50
    clear_stats(8'h55, 16'hC100, 16'hC29F);
    cpu_write(16'hFF46, 8'hC1);
    wait_writes(50);
    cpu_write(16'hFF46, 8'hC2);
    wait_done("rs");
    check("rs_oam", 32'(oam_diff(16'hC200, 0, 159)), 32'd0);
    check("rs_done_cnt", 32'(done_cnt), 32'd1);
    check("rs_oob", 32'(oob), 32'd0);

    // Reset while reading byte 80
    clear_stats(8'h33, 16'hC100, 16'hC19F);
    cpu_write(16'hFF46, 8'hC1);
    wait_writes(80);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("mid_rst_addr", 32'(dma_addr_select), 32'hFFFF);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_we", 32'(dma_write_enable), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (600) @(negedge clk);
    #1;
    check("mid_rst_done", 32'(done_cnt), 32'd0);
    check("mid_rst_wr_cnt", 32'(wr_cnt), 32'd80);
    check("mid_rst_head", 32'(oam_diff(16'hC100, 0, 79)), 32'd0);
    check("mid_rst_tail", 32'(oam_fill_diff(8'h33, 80, 159)), 32'd0);
    reg_addr_select = 16'hFF46; #1;
    check("mid_rst_page", 32'(reg_read_out), 32'h00);

    // Transfer from page 80, timing checked again
    clear_stats(8'h00, 16'h8000, 16'h809F);
    cpu_write(16'hFF46, 8'h80);
    wait_done("p80");
    check("p80_oam", 32'(oam_diff(16'h8000, 0, 159)), 32'd0);
    check("p80_busy_len", 32'(busy_cnt), 32'(BUSY_EXP));
    check("p80_gap", 32'(gap_bad), 32'd0);
    check("p80_done_cnt", 32'(done_cnt), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
